// File: rtl/datapath_if.sv
// Control/bus bundle for the single-bus CPU datapath.
// The control side (bench today, control unit later) drives the strobes.
// The datapath drives the bus value and every register's contents back out.
interface datapath_if;
  // Bus source selects
  logic        PCout;
  logic        Zhighout;
  logic        Zlowout;
  logic        MDRout;
  logic        R2out;
  logic        R3out;

  // Register load enables
  logic        MARin;
  logic        Zin;
  logic        PCin;
  logic        MDRin;
  logic        IRin;
  logic        Yin;
  logic        R1in;
  logic        R2in;
  logic        R3in;

  // ALU / memory controls
  logic        IncPC;
  logic        Read;
  logic [4:0]  AND;
  logic [31:0] Mdatain;

  // Datapath observation
  logic [31:0] BusMuxOut;
  logic [31:0] PC_q;
  logic [31:0] IR_q;
  logic [31:0] MAR_q;
  logic [31:0] MDR_q;
  logic [31:0] Y_q;
  logic [31:0] R1_q;
  logic [31:0] R2_q;
  logic [31:0] R3_q;
  logic [31:0] Zhigh_q;
  logic [31:0] Zlow_q;

  // Control side: issues one micro-op per clock and watches the datapath
  modport master (
    output PCout, Zhighout, Zlowout, MDRout, R2out, R3out,
    output MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in,
    output IncPC, Read, AND, Mdatain,
    input  BusMuxOut, PC_q, IR_q, MAR_q, MDR_q, Y_q,
    input  R1_q, R2_q, R3_q, Zhigh_q, Zlow_q
  );

  // Datapath side
  modport slave (
    input  PCout, Zhighout, Zlowout, MDRout, R2out, R3out,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, R1in, R2in, R3in,
    input  IncPC, Read, AND, Mdatain,
    output BusMuxOut, PC_q, IR_q, MAR_q, MDR_q, Y_q,
    output R1_q, R2_q, R3_q, Zhigh_q, Zlow_q
  );
endinterface

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: R1-R3, PC, IR, MAR, MDR, Y, 64-bit Z,
// a combinational ALU (A = Y, B = bus) and one shared priority-muxed bus.
// Every transfer is one externally strobed micro-op per clock.
module datapath (
  input  logic        Clock,
  input  logic        Clear,
  datapath_if.slave   dp
);

  typedef enum logic [4:0] {
    OP_PASS = 5'd0,
    OP_AND  = 5'd1,
    OP_OR   = 5'd2,
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_SHR  = 5'd5,
    OP_SHL  = 5'd6,
    OP_NOT  = 5'd7,
    OP_NEG  = 5'd8,
    OP_MUL  = 5'd9
  } alu_op_e;

  logic [31:0] pc_q,  pc_d;
  logic [31:0] ir_q,  ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q,   y_d;
  logic [31:0] r1_q,  r1_d;
  logic [31:0] r2_q,  r2_d;
  logic [31:0] r3_q,  r3_d;
  logic [63:0] z_q,   z_d;

  logic [31:0]        bus;
  logic [63:0]        alu_result;
  logic signed [63:0] mul_a;
  logic signed [63:0] mul_b;
  logic signed [63:0] mul_p;

  // Shared bus: fixed-priority select so overlapping strobes stay deterministic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    bus = 32'h0;
    if      (dp.PCout)    bus = pc_q;
    else if (dp.Zhighout) bus = z_q[63:32];
    else if (dp.Zlowout)  bus = z_q[31:0];
    else if (dp.MDRout)   bus = mdr_q;
    else if (dp.R2out)    bus = r2_q;
    else if (dp.R3out)    bus = r3_q;
  end

  // Signed multiply operands, sign-extended so the full product fits in Z
  assign mul_a = $signed(y_q);
  assign mul_b = $signed(bus);
  assign mul_p = mul_a * mul_b;

  // ALU: IncPC overrides the opcode; unused opcodes produce zero
  always_comb begin
    alu_result = 64'h0;
    if (dp.IncPC) begin
      alu_result = {32'h0, bus + 32'd1};
    end else begin
      case (alu_op_e'(dp.AND))
        OP_PASS: alu_result = {32'h0, bus};
        OP_AND:  alu_result = {32'h0, y_q & bus};
        OP_OR:   alu_result = {32'h0, y_q | bus};
        OP_ADD:  alu_result = {32'h0, y_q + bus};
        OP_SUB:  alu_result = {32'h0, y_q - bus};
        OP_SHR:  alu_result = {32'h0, y_q >> bus[4:0]};
        OP_SHL:  alu_result = {32'h0, y_q << bus[4:0]};
        OP_NOT:  alu_result = {32'h0, ~bus};
        OP_NEG:  alu_result = {32'h0, 32'h0 - bus};
        OP_MUL:  alu_result = mul_p;
        default: alu_result = 64'h0;
      endcase
    end
  end

  // Next-state selection: each register holds unless its load enable is set
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    r3_d  = r3_q;
    z_d   = z_q;
    if (dp.PCin)  pc_d  = bus;
    if (dp.IRin)  ir_d  = bus;
    if (dp.MARin) mar_d = bus;
    if (dp.MDRin) mdr_d = dp.Read ? dp.Mdatain : bus;
    if (dp.Yin)   y_d   = bus;
    if (dp.R1in)  r1_d  = bus;
    if (dp.R2in)  r2_d  = bus;
    if (dp.R3in)  r3_d  = bus;
    if (dp.Zin)   z_d   = alu_result;
  end

  // Register file state; Clear zeroes everything immediately, independent of Clock
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      pc_q  <= 32'h0;
      ir_q  <= 32'h0;
      mar_q <= 32'h0;
      mdr_q <= 32'h0;
      y_q   <= 32'h0;
      r1_q  <= 32'h0;
      r2_q  <= 32'h0;
      r3_q  <= 32'h0;
      z_q   <= 64'h0;
    end else begin
      // NOTE: non-blocking updates mean a register read on the bus this edge still shows its old value.
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      z_q   <= z_d;
    end
  end

  assign dp.BusMuxOut = bus;
  assign dp.PC_q      = pc_q;
  assign dp.IR_q      = ir_q;
  assign dp.MAR_q     = mar_q;
  assign dp.MDR_q     = mdr_q;
  assign dp.Y_q       = y_q;
  assign dp.R1_q      = r1_q;
  assign dp.R2_q      = r2_q;
  assign dp.R3_q      = r3_q;
  assign dp.Zhigh_q   = z_q[63:32];
  assign dp.Zlow_q    = z_q[31:0];

endmodule

// File: tb/tb_datapath.sv
// Directed bench for the single-bus datapath: micro-op sequences with
// hand-computed expected register and bus values.
module tb_datapath;

  logic clock;
  logic clear;
  int   errors;
  int   checks;

  datapath_if dif ();

  datapath dut (
    .Clock (clock),
    .Clear (clear),
    .dp    (dif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drop every strobe; Mdatain is left alone
  task automatic idle();
    dif.PCout = 0; dif.Zhighout = 0; dif.Zlowout = 0; dif.MDRout = 0;
    dif.R2out = 0; dif.R3out = 0;
    dif.MARin = 0; dif.Zin = 0; dif.PCin = 0; dif.MDRin = 0; dif.IRin = 0;
    dif.Yin = 0; dif.R1in = 0; dif.R2in = 0; dif.R3in = 0;
    dif.IncPC = 0; dif.Read = 0; dif.AND = 5'd0;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] val);
    idle();
    dif.Mdatain = val; dif.Read = 1; dif.MDRin = 1;
    tick();
  endtask

  // MDRout drives B; Z captures the result of opcode op against Y
  task automatic alu_step(input string tag, input logic [4:0] op,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    idle();
    dif.MDRout = 1; dif.AND = op; dif.Zin = 1;
    tick();
    check({tag, "_lo"}, dif.Zlow_q, exp_lo);
    check({tag, "_hi"}, dif.Zhigh_q, exp_hi);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    dif.Mdatain = 32'h0;
    idle();
    clear = 1'b1;
    #12;
    clear = 1'b0;
    #1;
    check("reset_pc", dif.PC_q, 32'h0);
    check("reset_zlo", dif.Zlow_q, 32'h0);
    check("idle_bus", dif.BusMuxOut, 32'h0);

    // Memory loads through MDR into R2, R3, R1
    load_mdr(32'h12);
    check("mdr_read", dif.MDR_q, 32'h12);
    idle(); dif.MDRout = 1; dif.R2in = 1; tick();
    check("r2_load", dif.R2_q, 32'h12);
    load_mdr(32'h14);
    idle(); dif.MDRout = 1; dif.R3in = 1; tick();
    check("r3_load", dif.R3_q, 32'h14);
    load_mdr(32'h18);
    idle(); dif.MDRout = 1; dif.R1in = 1; tick();
    check("r1_load", dif.R1_q, 32'h18);

    // Instruction fetch
    idle(); dif.PCout = 1; dif.MARin = 1; dif.IncPC = 1; dif.Zin = 1; tick();
    check("fetch_mar", dif.MAR_q, 32'h0);
    check("fetch_zinc", dif.Zlow_q, 32'h1);
    idle(); dif.Zlowout = 1; dif.PCin = 1; dif.Read = 1; dif.MDRin = 1;
    dif.Mdatain = 32'h28918000; tick();
    check("fetch_pc", dif.PC_q, 32'h1);
    check("fetch_mdr", dif.MDR_q, 32'h28918000);
    idle(); dif.MDRout = 1; dif.IRin = 1; tick();
    check("fetch_ir", dif.IR_q, 32'h28918000);

    // AND R1, R2, R3
    idle(); dif.R2out = 1; dif.Yin = 1; tick();
    check("and_y", dif.Y_q, 32'h12);
    idle(); dif.R3out = 1; dif.AND = 5'd1; dif.Zin = 1; tick();
    check("and_zlo", dif.Zlow_q, 32'h10);
    check("and_zhi", dif.Zhigh_q, 32'h0);
    idle(); dif.Zlowout = 1; dif.R1in = 1; tick();
    check("and_r1", dif.R1_q, 32'h10);

    // Signed multiply, add wrap, subtract underflow
    load_mdr(32'hFFFFFFFF);
    idle(); dif.MDRout = 1; dif.Yin = 1; tick();
    check("y_ones", dif.Y_q, 32'hFFFFFFFF);
    load_mdr(32'h2);
    alu_step("mul_neg", 5'd9, 32'hFFFFFFFE, 32'hFFFFFFFF);
    idle(); dif.Zhighout = 1; dif.Zlowout = 1; #1;
    check("prio_zhi_zlo", dif.BusMuxOut, 32'hFFFFFFFF);
    idle(); dif.Zlowout = 1; dif.MDRout = 1; #1;
    check("prio_zlo_mdr", dif.BusMuxOut, 32'hFFFFFFFE);
    alu_step("add_wrap", 5'd3, 32'h1, 32'h0);
    idle(); dif.Yin = 1; tick();
    check("y_from_idle_bus", dif.Y_q, 32'h0);
    load_mdr(32'h1);
    alu_step("sub_under", 5'd4, 32'hFFFFFFFF, 32'h0);

    // Remaining opcodes with Y=0xF0, B=4
    load_mdr(32'hF0);
    idle(); dif.MDRout = 1; dif.Yin = 1; tick();
    load_mdr(32'h4);
    alu_step("pass", 5'd0, 32'h4, 32'h0);
    alu_step("or", 5'd2, 32'hF4, 32'h0);
    alu_step("and0", 5'd1, 32'h0, 32'h0);
    alu_step("shr", 5'd5, 32'hF, 32'h0);
    alu_step("shl", 5'd6, 32'hF00, 32'h0);
    alu_step("not", 5'd7, 32'hFFFFFFFB, 32'h0);
    alu_step("neg", 5'd8, 32'hFFFFFFFC, 32'h0);
    alu_step("mul_pos", 5'd9, 32'h3C0, 32'h0);
    alu_step("op_unused", 5'd12, 32'h0, 32'h0);
    alu_step("neg2", 5'd8, 32'hFFFFFFFC, 32'h0);

    // Same-edge read and write of Z
    idle(); dif.Zlowout = 1; dif.IncPC = 1; dif.Zin = 1; dif.AND = 5'd1; tick();
    check("z_same_edge", dif.Zlow_q, 32'hFFFFFFFD);

    // Bus priority PC over R2, then PC increment wrap
    idle(); dif.PCout = 1; dif.R2out = 1; #1;
    check("prio_pc_r2", dif.BusMuxOut, 32'h1);
    idle(); dif.R2out = 1; dif.R3out = 1; #1;
    check("prio_r2_r3", dif.BusMuxOut, 32'h12);
    load_mdr(32'hFFFFFFFF);
    idle(); dif.MDRout = 1; dif.PCin = 1; tick();
    check("pc_ones", dif.PC_q, 32'hFFFFFFFF);
    idle(); dif.PCout = 1; dif.IncPC = 1; dif.Zin = 1; tick();
    check("inc_wrap_zhi", dif.Zhigh_q, 32'h0);
    idle(); dif.Zlowout = 1; dif.PCin = 1; tick();
    check("pc_wrap", dif.PC_q, 32'h0);

    // Mid-cycle Clear with no clock edge
    idle();
    @(negedge clock);
    #1;
    clear = 1'b1;
    #1;
    check("clr_pc", dif.PC_q, 32'h0);
    check("clr_ir", dif.IR_q, 32'h0);
    check("clr_mar", dif.MAR_q, 32'h0);
    check("clr_mdr", dif.MDR_q, 32'h0);
    check("clr_y", dif.Y_q, 32'h0);
    check("clr_r1", dif.R1_q, 32'h0);
    check("clr_r2", dif.R2_q, 32'h0);
    check("clr_r3", dif.R3_q, 32'h0);
    check("clr_zhi", dif.Zhigh_q, 32'h0);
    check("clr_zlo", dif.Zlow_q, 32'h0);
    check("clr_bus", dif.BusMuxOut, 32'h0);
    clear = 1'b0;
    tick();
    check("post_clr_ir", dif.IR_q, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
